// File: rtl/rover_motor_pwm.sv
// Multi-channel signed-duty PWM generator with reversal deadtime and command watchdog.
// Optional build macro MOTOR_RAMP_EN: slew-limit the active duty by RAMP_STEP per PWM period.
module rover_motor_pwm #(
    parameter int  CHANNELS   = 6,
    parameter int  PWM_BITS   = 10,
    parameter int  PRESCALE   = 4,
    parameter int  WDT_CYCLES = 1000000,
    parameter int  RAMP_STEP  = 8,
    localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                OSCCLK,
    input  logic                SYSRST,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CHAN_W-1:0]   cmd_chan,
    input  logic [PWM_BITS:0]   cmd_duty,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CHANNELS-1:0] dir_out,
    output logic                period_start,
    output logic                cmd_err,
    output logic                wdt_timeout
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [WDT_W-1:0]    WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    localparam logic [CHAN_W:0]     CHAN_LIM = (CHAN_W + 1)'(CHANNELS);
    localparam logic [PWM_BITS-1:0] CNT_LAST = {PWM_BITS{1'b1}};
`ifdef MOTOR_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif
    // Without ramping the step exceeds any possible duty difference, so the duty jumps.
    localparam int STEP_I = RAMP_EN ? RAMP_STEP : (1 << PWM_BITS);
    localparam logic [PWM_BITS:0] STEP = (PWM_BITS + 1)'(STEP_I);

    typedef enum logic {ST_RUN = 1'b0, ST_DEAD = 1'b1} ch_state_e;

    function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                        input logic [PWM_BITS-1:0] tgt);
        logic [PWM_BITS:0] diff;
        if (tgt > cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            step_toward = (diff > STEP) ? (cur + STEP[PWM_BITS-1:0]) : tgt;
        end else begin
            diff = {1'b0, cur} - {1'b0, tgt};
            step_toward = (diff > STEP) ? (cur - STEP[PWM_BITS-1:0]) : tgt;
        end
    endfunction

    logic                cmd_ready_q;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                period_start_q, period_start_d;
    logic                cmd_err_q, cmd_err_d;
    logic [WDT_W-1:0]    wdt_q, wdt_d;
    logic                wdt_timeout_q, wdt_timeout_d;
    logic [PWM_BITS-1:0] tgt_mag_q [CHANNELS];
    logic [PWM_BITS-1:0] tgt_mag_d [CHANNELS];
    logic [PWM_BITS-1:0] act_mag_q [CHANNELS];
    logic [PWM_BITS-1:0] act_mag_d [CHANNELS];
    ch_state_e           st_q [CHANNELS];
    ch_state_e           st_d [CHANNELS];
    logic [CHANNELS-1:0] tgt_dir_q, tgt_dir_d;
    logic [CHANNELS-1:0] dir_q, dir_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;

    logic                accept_s, chan_ok_s, tick_s, wrap_s, wdt_fire_s;
    logic [PWM_BITS:0]   abs_s;
    logic [PWM_BITS-1:0] cmd_mag_s;

    // Handshake decode, prescaler, period counter and watchdog next state.
    always_comb begin
        accept_s   = cmd_valid & cmd_ready_q;
        chan_ok_s  = ({1'b0, cmd_chan} < CHAN_LIM);
        abs_s      = cmd_duty[PWM_BITS] ? (~cmd_duty + (PWM_BITS + 1)'(1)) : cmd_duty;
        cmd_mag_s  = abs_s[PWM_BITS] ? {PWM_BITS{1'b1}} : abs_s[PWM_BITS-1:0];
        tick_s     = (pre_q == PRE_LAST);
        wrap_s     = tick_s && (cnt_q == CNT_LAST);
        pre_d      = tick_s ? {PRE_W{1'b0}} : (pre_q + PRE_W'(1));
        cnt_d      = tick_s ? (cnt_q + PWM_BITS'(1)) : cnt_q;
        period_start_d = wrap_s;
        cmd_err_d  = accept_s & ~chan_ok_s;
        wdt_fire_s = (wdt_q == WDT_LAST);
        if (accept_s) begin
            wdt_d         = {WDT_W{1'b0}};
            wdt_timeout_d = 1'b0;
        end else if (wdt_fire_s) begin
            wdt_d         = wdt_q;
            wdt_timeout_d = 1'b1;
        end else begin
            wdt_d         = wdt_q + WDT_W'(1);
            wdt_timeout_d = wdt_timeout_q;
        end
    end

    // Per-channel target capture and RUN/DEADTIME sequencing at period boundaries.
    always_comb begin
        tgt_dir_d = tgt_dir_q;
        dir_d     = dir_q;
        pwm_d     = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            tgt_mag_d[i] = tgt_mag_q[i];
            act_mag_d[i] = act_mag_q[i];
            st_d[i]      = st_q[i];
            // A command accepted together with a watchdog expiry still lands on its channel.
            if (accept_s && chan_ok_s && (cmd_chan == CHAN_W'(i))) begin
                tgt_mag_d[i] = cmd_mag_s;
                tgt_dir_d[i] = cmd_duty[PWM_BITS];
            end else if (wdt_fire_s) begin
                tgt_mag_d[i] = {PWM_BITS{1'b0}};
            end else begin
                tgt_mag_d[i] = tgt_mag_q[i];
            end
            if (wrap_s) begin
                case (st_q[i])
                    ST_RUN: begin
                        if ((tgt_mag_q[i] != {PWM_BITS{1'b0}}) && (tgt_dir_q[i] != dir_q[i])) begin
                            if (!RAMP_EN || (act_mag_q[i] == {PWM_BITS{1'b0}})) begin
                                st_d[i]      = ST_DEAD;
                                act_mag_d[i] = {PWM_BITS{1'b0}};
                            end else begin
                                act_mag_d[i] = step_toward(act_mag_q[i], {PWM_BITS{1'b0}});
                            end
                        end else begin
                            act_mag_d[i] = step_toward(act_mag_q[i], tgt_mag_q[i]);
                        end
                    end
                    ST_DEAD: begin
                        st_d[i]      = ST_RUN;
                        act_mag_d[i] = step_toward({PWM_BITS{1'b0}}, tgt_mag_q[i]);
                        dir_d[i]     = (tgt_mag_q[i] != {PWM_BITS{1'b0}}) ? tgt_dir_q[i] : dir_q[i];
                    end
                    default: begin
                        st_d[i]      = ST_RUN;
                        act_mag_d[i] = {PWM_BITS{1'b0}};
                    end
                endcase
            end else begin
                st_d[i] = st_q[i];
            end
            pwm_d[i] = (cnt_d < act_mag_d[i]);
        end
    end

    // State registers; PWM output computed from next-state so it lines up with the counter.
    always_ff @(posedge OSCCLK or negedge SYSRST) begin
        if (!SYSRST) begin
            cmd_ready_q    <= 1'b0;
            pre_q          <= {PRE_W{1'b0}};
            cnt_q          <= {PWM_BITS{1'b0}};
            period_start_q <= 1'b0;
            cmd_err_q      <= 1'b0;
            wdt_q          <= {WDT_W{1'b0}};
            wdt_timeout_q  <= 1'b0;
            tgt_dir_q      <= {CHANNELS{1'b0}};
            dir_q          <= {CHANNELS{1'b0}};
            pwm_q          <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                tgt_mag_q[i] <= {PWM_BITS{1'b0}};
                act_mag_q[i] <= {PWM_BITS{1'b0}};
                st_q[i]      <= ST_RUN;
            end
        end else begin
            cmd_ready_q    <= 1'b1;
            pre_q          <= pre_d;
            cnt_q          <= cnt_d;
            period_start_q <= period_start_d;
            cmd_err_q      <= cmd_err_d;
            wdt_q          <= wdt_d;
            wdt_timeout_q  <= wdt_timeout_d;
            tgt_dir_q      <= tgt_dir_d;
            dir_q          <= dir_d;
            pwm_q          <= pwm_d;
            for (int i = 0; i < CHANNELS; i++) begin
                tgt_mag_q[i] <= tgt_mag_d[i];
                act_mag_q[i] <= act_mag_d[i];
                st_q[i]      <= st_d[i];
            end
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign pwm_out      = pwm_q;
    assign dir_out      = dir_q;
    assign period_start = period_start_q;
    assign cmd_err      = cmd_err_q;
    assign wdt_timeout  = wdt_timeout_q;

endmodule

// File: tb/tb_rover_motor_pwm.sv
// Directed bench for rover_motor_pwm: 6 channels, 4-bit PWM, no prescale, 100-cycle watchdog.
module tb_rover_motor_pwm;

    localparam int CH = 6;
    localparam int PB = 4;
    localparam int PERIOD = 16;

    logic          OSCCLK;
    logic          SYSRST;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_chan;
    logic [PB:0]   cmd_duty;
    logic [CH-1:0] pwm_out;
    logic [CH-1:0] dir_out;
    logic          period_start;
    logic          cmd_err;
    logic          wdt_timeout;

    int n_checks = 0;
    int n_passed = 0;
    int cyc = 0;
    int c0;
    int ps_cnt;
    int tot;
    int hi_cnt [CH];
    int dir_snap [CH];

    rover_motor_pwm #(
        .CHANNELS(CH), .PWM_BITS(PB), .PRESCALE(1), .WDT_CYCLES(100), .RAMP_STEP(2)
    ) dut (
        .OSCCLK(OSCCLK), .SYSRST(SYSRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_chan(cmd_chan), .cmd_duty(cmd_duty), .pwm_out(pwm_out), .dir_out(dir_out),
        .period_start(period_start), .cmd_err(cmd_err), .wdt_timeout(wdt_timeout)
    );

    initial OSCCLK = 1'b0;
    always #5 OSCCLK = ~OSCCLK;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge OSCCLK);
        #1;
        cyc++;
    endtask

    task automatic send(input int ch, input int duty);
        cmd_valid = 1'b1;
        cmd_chan  = 3'(ch);
        cmd_duty  = 5'(duty);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Always advances at least one cycle, then stops on a period_start cycle.
    task automatic wait_ps();
        int budget;
        budget = 0;
        tick();
        while (period_start !== 1'b1 && budget < 64) begin
            tick();
            budget++;
        end
        check_eq("period_start_seen", int'(period_start === 1'b1), 1);
    endtask

    // Samples one full period starting at the current period_start cycle.
    task automatic measure();
        ps_cnt = 0;
        for (int c = 0; c < CH; c++) begin
            hi_cnt[c]   = 0;
            dir_snap[c] = int'(dir_out[c]);
        end
        for (int k = 0; k < PERIOD; k++) begin
            for (int c = 0; c < CH; c++) hi_cnt[c] += int'(pwm_out[c]);
            ps_cnt += int'(period_start);
            tick();
        end
    endtask

    initial begin
        SYSRST = 1'b0; cmd_valid = 1'b1; cmd_chan = 3'd0; cmd_duty = 5'd0;
        repeat (3) tick();
        check_eq("rst_cmd_ready", int'(cmd_ready), 0);
        check_eq("rst_pwm_out", int'(pwm_out), 0);
        check_eq("rst_dir_out", int'(dir_out), 0);
        check_eq("rst_period_start", int'(period_start), 0);
        check_eq("rst_wdt_timeout", int'(wdt_timeout), 0);
        SYSRST = 1'b1;
        cmd_valid = 1'b0;
        check_eq("ready_at_release", int'(cmd_ready), 0);
        tick();
        check_eq("ready_after_release", int'(cmd_ready), 1);

        // Forward duty on channel 2
        send(2, 5);
        wait_ps();
        measure();
        check_eq("ch2_fwd5_high", hi_cnt[2], 5);
        check_eq("ch2_fwd5_dir", dir_snap[2], 0);
        check_eq("ch0_idle_high", hi_cnt[0], 0);
        check_eq("one_ps_per_period", ps_cnt, 1);

        // Most-negative duty: deadtime, then saturated magnitude in reverse
        send(2, -16);
        wait_ps();
        measure();
        check_eq("ch2_dead_high", hi_cnt[2], 0);
        check_eq("ch2_dead_dir", dir_snap[2], 0);
        measure();
        check_eq("ch2_sat_high", hi_cnt[2], 15);
        check_eq("ch2_sat_dir", dir_snap[2], 1);

        // Reversal on channel 0
        send(0, 8);
        wait_ps();
        measure();
        check_eq("ch0_fwd8_high", hi_cnt[0], 8);
        check_eq("ch0_fwd8_dir", dir_snap[0], 0);
        send(0, -8);
        wait_ps();
        measure();
        check_eq("ch0_dead_high", hi_cnt[0], 0);
        check_eq("ch0_dead_dir", dir_snap[0], 0);
        measure();
        check_eq("ch0_rev8_high", hi_cnt[0], 8);
        check_eq("ch0_rev8_dir", dir_snap[0], 1);
        check_eq("ch2_kept_high", hi_cnt[2], 15);

        // Two commands to one channel: last one wins
        send(4, 3);
        send(4, 9);
        wait_ps();
        measure();
        check_eq("ch4_last_wins", hi_cnt[4], 9);

        // Bad channel: error pulse, outputs unchanged, watchdog restarted
        send(7, 3);
        c0 = cyc;
        check_eq("bad_chan_err", int'(cmd_err), 1);
        tick();
        check_eq("bad_chan_err_clear", int'(cmd_err), 0);
        wait_ps();
        measure();
        check_eq("bad_ch0_high", hi_cnt[0], 8);
        check_eq("bad_ch2_high", hi_cnt[2], 15);
        check_eq("bad_ch4_high", hi_cnt[4], 9);
        while (cyc - c0 < 99) tick();
        check_eq("wdt_before_expiry", int'(wdt_timeout), 0);
        tick();
        check_eq("wdt_at_expiry", int'(wdt_timeout), 1);
        wait_ps();
        measure();
        tot = 0;
        for (int c = 0; c < CH; c++) tot += hi_cnt[c];
        check_eq("wdt_all_stopped", tot, 0);
        check_eq("wdt_ch0_dir_kept", dir_snap[0], 1);
        check_eq("wdt_ch2_dir_kept", dir_snap[2], 1);
        check_eq("wdt_still_set", int'(wdt_timeout), 1);

        // Recovery command, then a command landing on the expiry cycle
        send(1, 6);
        c0 = cyc;
        check_eq("wdt_cleared_by_cmd", int'(wdt_timeout), 0);
        wait_ps();
        measure();
        check_eq("ch1_fwd6_high", hi_cnt[1], 6);
        while (cyc - c0 < 99) tick();
        check_eq("wdt_pre_race", int'(wdt_timeout), 0);
        send(3, 4);
        check_eq("wdt_race_cmd_wins", int'(wdt_timeout), 0);
        wait_ps();
        measure();
        check_eq("race_ch3_high", hi_cnt[3], 4);
        check_eq("race_ch3_dir", dir_snap[3], 0);
        check_eq("race_ch1_zeroed", hi_cnt[1], 0);
        check_eq("race_wdt_low", int'(wdt_timeout), 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

// File: doc/rover_motor_pwm.md
Name: rover_motor_pwm

Overview:
- Multi-channel signed-duty PWM generator driving the rover drive/steer motor controllers; instantiated under urcRover.
- Accepts per-channel speed commands over a valid/ready handshake and applies them glitch-free at PWM period boundaries.
- Adds direction-reversal deadtime and a command watchdog that stops all motors when commands stop arriving.

Parameters:
CHANNELS, 6, number of motor channels (1..16)
PWM_BITS, 10, PWM counter width; period = 2^PWM_BITS ticks
PRESCALE, 4, OSCCLK cycles per PWM tick (>=1)
WDT_CYCLES, 1000000, OSCCLK cycles without an accepted command before stop
RAMP_STEP, 8, max duty magnitude change per PWM period (ramp build only)

Ports:
OSCCLK  in  1  system clock
SYSRST  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_chan  in  $clog2(CHANNELS) (min 1)  target channel
cmd_duty  in  PWM_BITS+1  signed duty; sign = direction (neg = reverse)
pwm_out  out  CHANNELS  PWM outputs
dir_out  out  CHANNELS  direction outputs, 1 = reverse
period_start  out  1  one-cycle pulse at PWM counter wrap to 0
cmd_err  out  1  one-cycle pulse: accepted command had cmd_chan >= CHANNELS
wdt_timeout  out  1  high while watchdog-stopped

Behaviour:
- Reset (SYSRST=0, async): all outputs 0 except cmd_ready=0; prescaler, PWM counter, target/active duty, dir, watchdog counter cleared.
- cmd_ready=1 every cycle out of reset; a command is accepted on cmd_valid & cmd_ready. Target register updated the cycle after acceptance.
- cmd_chan >= CHANNELS: command dropped, cmd_err pulses the following cycle; it still restarts the watchdog.
- Magnitude: |cmd_duty| saturates to 2^PWM_BITS-1 (the most-negative value gives full reverse).
- Prescaler counts 0..PRESCALE-1; tick on PRESCALE-1. PWM counter increments on tick, wraps 2^PWM_BITS-1 -> 0; period_start pulses in the cycle the counter becomes 0.
- Active duty/dir per channel loaded from target only on period_start. No mid-period change.
- pwm_out[i] = registered (pwm_cnt < active_mag[i]). Mag 0 -> constant 0; max mag -> low for exactly one tick per period.
- Direction reversal: when the target sign differs from dir_out[i] and target mag != 0, the channel enters DEADTIME. Active mag is forced 0 for one full period, then dir_out and mag update at the next period_start. A command arriving during DEADTIME replaces the target; if it restores the original sign, DEADTIME is abandoned at the next boundary.
- Per-channel FSM: RUN -> DEADTIME (sign change seen at period_start) -> RUN (next period_start).
- Watchdog counts OSCCLK cycles and clears on any accepted command. On reaching WDT_CYCLES-1, all targets are zeroed (dir kept) and wdt_timeout is set; it stays set until the next accepted command.
- Simultaneous timeout and command in the same cycle: the command wins. The counter clears, wdt_timeout stays/returns 0, the commanded channel takes the new target, and other channels are zeroed.
- Two commands to the same channel within one period: the last one wins.

Optional Feature:
MOTOR_RAMP_EN defined: at each period_start, active signed duty moves toward target by at most RAMP_STEP. A sign change ramps to 0 first, then DEADTIME applies, then ramps up. The watchdog stop also ramps.
MOTOR_RAMP_EN undefined: active duty jumps to target at period_start (DEADTIME still applied).

Test Plan:
1. Reset: hold SYSRST=0 with cmd_valid=1 -> cmd_ready=0, pwm_out=0, dir_out=0; release -> cmd_ready=1 next cycle.
2. Duty: PWM_BITS=4, PRESCALE=1, chan 2 duty +5 -> from next period_start pwm_out[2] high 5 of 16 cycles, dir_out[2]=0; duty -16 -> saturates to mag 15, dir=1 after deadtime.
3. Reversal: chan 0 at +8, command -8 -> one full period with pwm_out[0]=0, then dir_out[0]=1 with 8/16 high.
4. Bad channel: cmd_chan=7 with CHANNELS=6 -> cmd_err pulse, no output change, watchdog restarted.
5. Watchdog: WDT_CYCLES=100, no commands -> wdt_timeout=1 at cycle 100, all pwm_out 0 from next period; command on the same cycle as timeout -> wdt_timeout stays 0, that channel keeps its new duty.
6. Ramp (MOTOR_RAMP_EN, RAMP_STEP=2): 0 -> +6 gives mags 2,4,6 over three periods; then -2 gives 4,2,0, deadtime, then 2 reverse.
